// File: rtl/sb_tx_arbiter_pkg.sv
// Shared MBINIT sideband TX arbiter package.
// FSM encoding, owner ids and timeout defaults.
package sb_tx_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_ISSUE     = 2'd1,
      ST_WAIT_DONE = 2'd2
   } sb_state_t;

   typedef enum logic {
      OWN_MOD = 1'b0,
      OWN_PTN = 1'b1
   } sb_owner_t;

   localparam int SB_TIMEOUT_DEF = 200;
   localparam int SB_CNT_W_DEF   = 8;

   function automatic sb_owner_t rr_other(input sb_owner_t o);
      return (o == OWN_MOD) ? OWN_PTN : OWN_MOD;
   endfunction

endpackage

// File: rtl/sb_tx_arbiter_rr_pick2.sv
// Two-way round-robin picker for the sideband TX arbiter.
// On contention the side not served last wins.
module rr_pick2
   import sb_tx_arbiter_pkg::*;
(
   input  logic req_mod,
   input  logic req_ptn,
   input  logic last,
   output logic any,
   output logic pick
);

   assign any = req_mod | req_ptn;

   always_comb begin
      pick = OWN_MOD;
      unique case (1'b1)
         req_mod && req_ptn:  pick = rr_other(sb_owner_t'(last));
         req_ptn && !req_mod: pick = OWN_PTN;
         default:             pick = OWN_MOD;
      endcase
   end

endmodule

// File: rtl/sb_tx_arbiter.sv
// Sideband TX arbiter: grants module/partner requests,
// issues one strobe, waits for busy falling edge or timeout.
module sb_tx_arbiter
   import sb_tx_arbiter_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = SB_TIMEOUT_DEF,
   parameter int CNT_W          = SB_CNT_W_DEF
) (
   input  logic       CLK,
   input  logic       rst_n,
   input  logic       i_flush,
   input  logic       i_req_mod,
   input  logic       i_req_ptn,
   input  logic [3:0] i_msg_mod,
   input  logic [3:0] i_msg_ptn,
   input  logic       i_dfp_mod,
   input  logic       i_dfp_ptn,
   input  logic       i_falling_edge_busy,
   output logic [3:0] o_TX_SbMessage,
   output logic       o_ValidOutDatat,
   output logic       o_ValidDataFieldParameters,
   output logic       o_ack_mod,
   output logic       o_ack_ptn,
   output logic       o_busy_mod,
   output logic       o_busy_ptn,
   output logic       o_timeout_err
);

   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   sb_state_t        state_q, state_d;
   sb_owner_t        owner_q, last_q;
   logic [3:0]       msg_q;
   logic             dfp_q;
   logic [CNT_W-1:0] cnt_q;
   logic             grant_any, pick;
   logic             done, expire;

   rr_pick2 u_pick (
      .req_mod (i_req_mod),
      .req_ptn (i_req_ptn),
      .last    (last_q),
      .any     (grant_any),
      .pick    (pick)
   );

   assign done   = (state_q == ST_WAIT_DONE) && i_falling_edge_busy;
   // Completion beats a timeout landing in the same cycle.
   assign expire = (state_q == ST_WAIT_DONE) && !i_falling_edge_busy &&
                   (cnt_q >= TO_LAST);

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (i_flush) begin
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE:      if (grant_any) state_d = ST_ISSUE;
            ST_ISSUE:     state_d = ST_WAIT_DONE;
            ST_WAIT_DONE: if (done || expire) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         owner_q <= OWN_MOD;
         last_q  <= OWN_PTN;
         msg_q   <= 4'h0;
         dfp_q   <= 1'b0;
         cnt_q   <= '0;
      end else if (i_flush) begin
         owner_q <= OWN_MOD;
         last_q  <= OWN_PTN;
         msg_q   <= 4'h0;
         dfp_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         if (state_q == ST_IDLE && grant_any) begin
            owner_q <= sb_owner_t'(pick);
            msg_q   <= pick ? i_msg_ptn : i_msg_mod;
            dfp_q   <= pick ? i_dfp_ptn : i_dfp_mod;
         end else if (state_d == ST_IDLE) begin
            msg_q <= 4'h0;
            dfp_q <= 1'b0;
         end
         if (done) last_q <= owner_q;
         if (state_q == ST_WAIT_DONE && !done) begin
            if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
         end else begin
            cnt_q <= '0;
         end
      end
   end

   always_comb begin
      o_TX_SbMessage             = msg_q;
      o_ValidDataFieldParameters = dfp_q;
      o_ValidOutDatat = (state_q == ST_ISSUE);
      o_busy_mod = (state_q != ST_IDLE) && (owner_q == OWN_MOD);
      o_busy_ptn = (state_q != ST_IDLE) && (owner_q == OWN_PTN);
      o_ack_mod  = done && !i_flush && (owner_q == OWN_MOD);
      o_ack_ptn  = done && !i_flush && (owner_q == OWN_PTN);
      o_timeout_err = expire && !i_flush;
   end

endmodule

// File: tb/tb_sb_tx_arbiter.sv
// Directed bench for sb_tx_arbiter.
// flags = {strobe, ack_mod, ack_ptn, busy_mod, busy_ptn, timeout}.
module tb_sb_tx_arbiter;

   logic       CLK = 1'b0;
   logic       rst_n, i_flush, i_req_mod, i_req_ptn;
   logic [3:0] i_msg_mod, i_msg_ptn;
   logic       i_dfp_mod, i_dfp_ptn, i_falling_edge_busy;
   logic [3:0] o_TX_SbMessage;
   logic       o_ValidOutDatat, o_ValidDataFieldParameters;
   logic       o_ack_mod, o_ack_ptn, o_busy_mod, o_busy_ptn;
   logic       o_timeout_err;
   logic [5:0] flags;
   logic [4:0] md;

   int total = 0;
   int bad = 0;
   int strobes = 0;
   int base;

   always #5 CLK = ~CLK;

   sb_tx_arbiter dut (
      .CLK                        (CLK),
      .rst_n                      (rst_n),
      .i_flush                    (i_flush),
      .i_req_mod                  (i_req_mod),
      .i_req_ptn                  (i_req_ptn),
      .i_msg_mod                  (i_msg_mod),
      .i_msg_ptn                  (i_msg_ptn),
      .i_dfp_mod                  (i_dfp_mod),
      .i_dfp_ptn                  (i_dfp_ptn),
      .i_falling_edge_busy        (i_falling_edge_busy),
      .o_TX_SbMessage             (o_TX_SbMessage),
      .o_ValidOutDatat            (o_ValidOutDatat),
      .o_ValidDataFieldParameters (o_ValidDataFieldParameters),
      .o_ack_mod                  (o_ack_mod),
      .o_ack_ptn                  (o_ack_ptn),
      .o_busy_mod                 (o_busy_mod),
      .o_busy_ptn                 (o_busy_ptn),
      .o_timeout_err              (o_timeout_err)
   );

   assign flags = {o_ValidOutDatat, o_ack_mod, o_ack_ptn,
                   o_busy_mod, o_busy_ptn, o_timeout_err};
   assign md = {o_TX_SbMessage, o_ValidDataFieldParameters};

   always @(posedge CLK) if (o_ValidOutDatat) strobes <= strobes + 1;

   task automatic step;
      @(posedge CLK);
      #1;
   endtask

   task automatic clear_inputs;
      i_flush = 0; i_req_mod = 0; i_req_ptn = 0;
      i_msg_mod = 0; i_msg_ptn = 0; i_dfp_mod = 0; i_dfp_ptn = 0;
      i_falling_edge_busy = 0;
   endtask

   task automatic pulse_reset;
      clear_inputs();
      @(negedge CLK);
      rst_n = 0;
      #2;
      rst_n = 1;
      step();
   endtask

   task automatic test_reset;
      clear_inputs();
      rst_n = 0;
      #13;
      total++;
      if (flags !== 6'b000000) begin
         bad++; $display("FAIL reset_flags got=%b exp=%b", flags, 6'b0);
      end
      total++;
      if (md !== 5'h00) begin
         bad++; $display("FAIL reset_msg got=%h exp=%h", md, 5'h00);
      end
      @(negedge CLK);
      rst_n = 1;
      step();
   endtask

   task automatic test_single;
      pulse_reset();
      i_req_mod = 1; i_msg_mod = 4'h5; i_dfp_mod = 1;
      #1;
      total++;
      if (flags !== 6'b000000) begin
         bad++; $display("FAIL single_idle got=%b exp=%b", flags, 6'b0);
      end
      step();
      i_req_mod = 0; i_msg_mod = 0; i_dfp_mod = 0;
      i_falling_edge_busy = 1;
      #1;
      total++;
      if (flags !== 6'b100100) begin
         bad++; $display("FAIL single_issue got=%b exp=%b", flags, 6'b100100);
      end
      total++;
      if (md !== {4'h5, 1'b1}) begin
         bad++; $display("FAIL single_msg got=%h exp=%h", md, {4'h5, 1'b1});
      end
      step();
      i_falling_edge_busy = 0;
      #1;
      total++;
      if (flags !== 6'b000100) begin
         bad++; $display("FAIL single_wait got=%b exp=%b", flags, 6'b000100);
      end
      step();
      step();
      i_falling_edge_busy = 1;
      #1;
      total++;
      if (flags !== 6'b010100) begin
         bad++; $display("FAIL single_ack got=%b exp=%b", flags, 6'b010100);
      end
      total++;
      if (md !== {4'h5, 1'b1}) begin
         bad++; $display("FAIL single_hold got=%h exp=%h", md, {4'h5, 1'b1});
      end
      step();
      #1;
      total++;
      if (flags !== 6'b000000) begin
         bad++; $display("FAIL single_idle_edge got=%b exp=%b", flags, 6'b0);
      end
      total++;
      if (md !== 5'h00) begin
         bad++; $display("FAIL single_clr got=%h exp=%h", md, 5'h00);
      end
      i_falling_edge_busy = 0;
      step();
   endtask

   task automatic test_back_to_back;
      pulse_reset();
      base = strobes;
      i_req_mod = 1; i_req_ptn = 1;
      i_msg_mod = 4'h2; i_msg_ptn = 4'h9; i_dfp_ptn = 1;
      step();
      #1;
      total++;
      if (flags !== 6'b100100 || md !== {4'h2, 1'b0}) begin
         bad++; $display("FAIL b2b_first got=%b/%h exp=%b/%h",
                         flags, md, 6'b100100, {4'h2, 1'b0});
      end
      step();
      i_falling_edge_busy = 1;
      #1;
      total++;
      if (flags !== 6'b010100) begin
         bad++; $display("FAIL b2b_ack_mod got=%b exp=%b", flags, 6'b010100);
      end
      step();
      i_falling_edge_busy = 0;
      #1;
      total++;
      if (flags !== 6'b000000) begin
         bad++; $display("FAIL b2b_gap got=%b exp=%b", flags, 6'b0);
      end
      step();
      #1;
      total++;
      if (flags !== 6'b100010 || md !== {4'h9, 1'b1}) begin
         bad++; $display("FAIL b2b_second got=%b/%h exp=%b/%h",
                         flags, md, 6'b100010, {4'h9, 1'b1});
      end
      step();
      i_falling_edge_busy = 1; i_req_ptn = 0;
      #1;
      total++;
      if (flags !== 6'b001010) begin
         bad++; $display("FAIL b2b_ack_ptn got=%b exp=%b", flags, 6'b001010);
      end
      step();
      i_falling_edge_busy = 0;
      #1;
      total++;
      if (strobes - base !== 2) begin
         bad++; $display("FAIL b2b_strobes got=%0d exp=%0d", strobes - base, 2);
      end
      step();
      i_req_mod = 0;
      #1;
      total++;
      if (flags !== 6'b100100) begin
         bad++; $display("FAIL b2b_rereq got=%b exp=%b", flags, 6'b100100);
      end
      step();
      i_falling_edge_busy = 1;
      step();
      i_falling_edge_busy = 0;
      step();
   endtask

   task automatic test_flush;
      pulse_reset();
      i_req_mod = 1; i_msg_mod = 4'h3;
      step();
      i_req_mod = 0;
      step();
      i_falling_edge_busy = 1;
      step();
      i_falling_edge_busy = 0;
      i_req_ptn = 1; i_msg_ptn = 4'hA;
      step();
      i_req_ptn = 0;
      step();
      i_flush = 1; i_falling_edge_busy = 1;
      #1;
      total++;
      if (flags !== 6'b000010) begin
         bad++; $display("FAIL flush_no_ack got=%b exp=%b", flags, 6'b000010);
      end
      step();
      i_flush = 0;
      i_req_mod = 1; i_req_ptn = 1;
      i_msg_mod = 4'h2; i_msg_ptn = 4'h9;
      #1;
      total++;
      if (flags !== 6'b000000 || md !== 5'h00) begin
         bad++; $display("FAIL flush_idle got=%b/%h exp=%b/%h",
                         flags, md, 6'b0, 5'h00);
      end
      step();
      i_req_mod = 0; i_req_ptn = 0; i_falling_edge_busy = 0;
      #1;
      total++;
      if (flags !== 6'b100100 || md !== {4'h2, 1'b0}) begin
         bad++; $display("FAIL flush_ptr got=%b/%h exp=%b/%h",
                         flags, md, 6'b100100, {4'h2, 1'b0});
      end
      step();
      i_falling_edge_busy = 1;
      step();
      i_falling_edge_busy = 0;
      step();
   endtask

   task automatic test_reset_mid;
      pulse_reset();
      i_req_ptn = 1; i_msg_ptn = 4'h7;
      step();
      i_req_ptn = 0;
      step();
      #1;
      total++;
      if (flags !== 6'b000010) begin
         bad++; $display("FAIL rstmid_wait got=%b exp=%b", flags, 6'b000010);
      end
      rst_n = 0;
      #1;
      total++;
      if (flags !== 6'b000000 || md !== 5'h00) begin
         bad++; $display("FAIL rstmid_async got=%b/%h exp=%b/%h",
                         flags, md, 6'b0, 5'h00);
      end
      @(negedge CLK);
      rst_n = 1;
      step();
      i_falling_edge_busy = 1;
      #1;
      total++;
      if (flags !== 6'b000000) begin
         bad++; $display("FAIL rstmid_no_ack got=%b exp=%b", flags, 6'b0);
      end
      step();
      i_falling_edge_busy = 0;
      step();
   endtask

   task automatic test_timeout;
      pulse_reset();
      i_req_mod = 1; i_msg_mod = 4'h1;
      step();
      i_req_mod = 0;
      step();
      i_falling_edge_busy = 1;
      step();
      i_falling_edge_busy = 0;
      i_req_ptn = 1; i_msg_ptn = 4'hC;
      step();
      i_req_ptn = 0;
      for (int k = 1; k <= 199; k++) step();
      #1;
      total++;
      if (flags !== 6'b000010) begin
         bad++; $display("FAIL to_199 got=%b exp=%b", flags, 6'b000010);
      end
      step();
      #1;
      total++;
      if (flags !== 6'b000011 || md !== {4'hC, 1'b0}) begin
         bad++; $display("FAIL to_200 got=%b/%h exp=%b/%h",
                         flags, md, 6'b000011, {4'hC, 1'b0});
      end
      step();
      i_req_mod = 1; i_req_ptn = 1;
      i_msg_mod = 4'h4; i_msg_ptn = 4'hD;
      #1;
      total++;
      if (flags !== 6'b000000 || md !== 5'h00) begin
         bad++; $display("FAIL to_idle got=%b/%h exp=%b/%h",
                         flags, md, 6'b0, 5'h00);
      end
      step();
      i_req_mod = 0; i_req_ptn = 0;
      #1;
      total++;
      if (flags !== 6'b100010 || md !== {4'hD, 1'b0}) begin
         bad++; $display("FAIL to_ptr got=%b/%h exp=%b/%h",
                         flags, md, 6'b100010, {4'hD, 1'b0});
      end
   endtask

   task automatic test_coincident;
      for (int k = 1; k <= 200; k++) step();
      i_falling_edge_busy = 1;
      #1;
      total++;
      if (flags !== 6'b001010) begin
         bad++; $display("FAIL coinc_ack got=%b exp=%b", flags, 6'b001010);
      end
      step();
      i_falling_edge_busy = 0;
      #1;
      total++;
      if (flags !== 6'b000000) begin
         bad++; $display("FAIL coinc_idle got=%b exp=%b", flags, 6'b0);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_flush();
      test_reset_mid();
      test_timeout();
      test_coincident();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

endmodule

// File: doc/sb_tx_arbiter.md
SB_TX_ARBITER -- requirements
Module: sb_tx_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 200: max cycles to wait for busy falling edge after issue.
REQ-002 SHALL have parameter CNT_W, default 8: width of the timeout counter; TIMEOUT_CYCLES SHALL be < 2**CNT_W.
REQ-003 SHALL have port CLK, input, 1: the single clock; all state SHALL be rising-edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port i_flush, input, 1: synchronous abort to IDLE; asserted on LTSM state exit.
REQ-006 SHALL have ports i_req_mod / i_req_ptn, input, 1 each: local-module and partner-module send requests.
REQ-007 SHALL have ports i_msg_mod / i_msg_ptn, input, 4 each: sideband message codes.
REQ-008 SHALL have ports i_dfp_mod / i_dfp_ptn, input, 1 each: message carries data-field parameters.
REQ-009 SHALL have port i_falling_edge_busy, input, 1: one-cycle pulse when the sideband finishes a message.
REQ-010 SHALL have port o_TX_SbMessage, output, 4: registered granted message code.
REQ-011 SHALL have port o_ValidOutDatat, output, 1: one-cycle issue strobe to the sideband.
REQ-012 SHALL have port o_ValidDataFieldParameters, output, 1: registered dfp of the granted message.
REQ-013 SHALL have ports o_ack_mod / o_ack_ptn, output, 1 each: one-cycle completion pulses.
REQ-014 SHALL have port o_busy_mod / o_busy_ptn, output, 1 each: high while that requester owns the sideband (ISSUE or WAIT_DONE).
REQ-015 SHALL have port o_timeout_err, output, 1: one-cycle pulse on timeout, consumed as train-error request.

Function
REQ-016 SHALL implement FSM states IDLE, ISSUE, WAIT_DONE.
REQ-017 IDLE: if any request is high, SHALL grant, latch message/dfp/owner, go to ISSUE next cycle; else stay.
REQ-018 Both requests high in IDLE: SHALL grant the requester not served last (round-robin); after reset the module has priority.
REQ-019 ISSUE: SHALL drive o_ValidOutDatat=1 for exactly this one cycle, clear the timeout counter, go to WAIT_DONE; i_falling_edge_busy SHALL be ignored in ISSUE.
REQ-020 Latency: request sampled high in IDLE at cycle N SHALL produce o_ValidOutDatat at N+1.
REQ-021 o_TX_SbMessage and o_ValidDataFieldParameters SHALL hold the latched values unchanged from ISSUE through WAIT_DONE; SHALL be 0 in IDLE.
REQ-022 WAIT_DONE: on i_falling_edge_busy SHALL pulse the owner's ack, update the last-served pointer, return to IDLE.
REQ-023 WAIT_DONE: counter SHALL increment each cycle without the edge; on reaching TIMEOUT_CYCLES SHALL pulse o_timeout_err, issue no ack, return to IDLE, keep the pointer unchanged.
REQ-024 Falling edge and timeout in the same cycle: completion SHALL win (ack, no error).
REQ-025 Requester dropping its request after grant SHALL NOT abort the transfer; ack SHALL still pulse.
REQ-026 A requester still requesting when its ack pulses SHALL be treated as a new request one cycle later (IDLE minimum one cycle between grants).
REQ-027 i_falling_edge_busy in IDLE SHALL be ignored.
REQ-028 i_flush SHALL take priority over all transitions: next state IDLE, outputs cleared, no ack, no error, pointer reset to module-priority.
REQ-029 Counter SHALL saturate, never wrap.

Reset
REQ-030 rst_n low SHALL asynchronously force IDLE, counter 0, pointer module-priority, all outputs 0.
REQ-031 Reset deassertion mid-transfer SHALL resume in IDLE with no pending ack.

Structure
REQ-032 State encoding and TIMEOUT_CYCLES default SHALL live in the shared MBINIT package.
REQ-033 SHALL be one module; the round-robin picker MAY be a sub-module rr_pick2; no other sub-modules.

Verification
REQ-034 Single req: i_req_mod=1, i_msg_mod=4'h5, edge 3 cycles after issue -> strobe at N+1, o_TX_SbMessage=5 held, o_ack_mod one pulse.
REQ-035 Simultaneous req after reset, messages 4'h2/4'h9 -> module served first, then partner; acks in that order; two issue strobes total.
REQ-036 No edge for 200 cycles -> o_timeout_err at cycle 200 in WAIT_DONE, no ack, FSM in IDLE.
REQ-037 Edge coincident with timeout cycle -> ack, no o_timeout_err.
REQ-038 i_flush and rst_n asserted in WAIT_DONE -> IDLE next cycle/immediately, outputs 0, later edge produces no ack.
REQ-039 Edge during ISSUE and in IDLE -> ignored; transfer completes only on a later edge.
